disp_mask_scale: RTL and testbench

Post-processing stage directly downstream of the per-pixel minimum-disparity selector. It consumes the packed disparity AXI-Stream (MAX_SAMPLES_PER_CLOCK disparities per beat, tuser = start of frame, tlast = end of line) and tracks frame geometry with column and line counters. It forces the leftmost MAX_DISP pixels of each line to 0, because they have no valid match, and scales each disparity by a left shift with saturation for display. It regenerates clean tuser/tlast markers, resynchronises on malformed frames and reports sticky geometry errors.

---
 rtl/disp_mask_scale_if.sv | 14 +
 rtl/disp_mask_scale.sv | 220 ++++++++++++++++++++++
 tb/tb_disp_mask_scale.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_mask_scale_if.sv
// Packed disparity AXI-Stream bundle shared by the input and output ports of
// disp_mask_scale.
interface disp_mask_scale_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tuser;

    modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/disp_mask_scale.sv
// Disparity post-processing: tracks frame geometry, masks the left border,
// scales each disparity by a saturating left shift and regenerates clean
// tuser/tlast markers. Malformed frames raise sticky error flags.
module disp_mask_scale #(
    parameter int MAX_DISP              = 64,
    parameter int MAX_SAMPLES_PER_CLOCK = 4,
    parameter int AXIS_TDATA_WIDTH      = 32,
    parameter int DATA_WIDTH            = 8,
    parameter int IMG_WIDTH             = 640,
    parameter int IMG_HEIGHT            = 480,
    parameter int SCALE_SHIFT           = 2
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    disp_mask_scale_if.slave          s_axis_disp,
    disp_mask_scale_if.master         m_axis_disp,
    input  logic                      err_clr,
    output logic                      err_short_line,
    output logic                      err_long_line,
    output logic                      err_sof_early,
    output logic                      frame_done,
    output logic [15:0]               drop_cnt
);
    localparam int N     = MAX_SAMPLES_PER_CLOCK;
    localparam int C     = IMG_WIDTH / N;
    localparam int COL_W = (C > 1) ? $clog2(C) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int WIDE_W = DATA_WIDTH + SCALE_SHIFT;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(C - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    state_t                      state_r, state_nxt_s;
    logic [COL_W-1:0]            col_r, col_nxt_s, eff_col_s;
    logic [ROW_W-1:0]            row_r, row_nxt_s, eff_row_s;
    logic                        s_ready_s, acc_s;
    logic                        fwd_s, restart_s, sof_early_s, drop_s;
    logic                        line_end_s, frame_end_s, short_s, long_s;
    logic                        out_tuser_s, out_tlast_s;
    logic [AXIS_TDATA_WIDTH-1:0] out_data_s;
    logic [31:0]                 pix_s;

    logic                        m_tvalid_r, m_tlast_r, m_tuser_r;
    logic [AXIS_TDATA_WIDTH-1:0] m_tdata_r;

    // Shift one disparity left and clip it to the largest DATA_WIDTH value.
    function automatic logic [DATA_WIDTH-1:0] sat_shift(input logic [DATA_WIDTH-1:0] d);
        logic [WIDE_W-1:0] w;
        w = WIDE_W'(d) << SCALE_SHIFT;
        if (|(w >> DATA_WIDTH)) begin
            return {DATA_WIDTH{1'b1}};
        end else begin
            return w[DATA_WIDTH-1:0];
        end
    endfunction

    assign s_ready_s          = m_axis_disp.tready | ~m_tvalid_r;
    assign s_axis_disp.tready = s_ready_s;
    assign acc_s              = s_axis_disp.tvalid & s_ready_s;

    assign m_axis_disp.tvalid = m_tvalid_r;
    assign m_axis_disp.tdata  = m_tdata_r;
    assign m_axis_disp.tlast  = m_tlast_r;
    assign m_axis_disp.tuser  = m_tuser_r;

    // Classify the current input beat, derive its effective position, markers,
    // processed data and the next state/counter values.
    always_comb begin
        state_nxt_s = state_r;
        col_nxt_s   = col_r;
        row_nxt_s   = row_r;
        fwd_s       = 1'b0;
        restart_s   = 1'b0;
        sof_early_s = 1'b0;
        drop_s      = 1'b0;
        pix_s       = 32'd0;
        out_data_s  = '0;

        case (state_r)
            WAIT_SOF: begin
                if (s_axis_disp.tuser) begin
                    fwd_s     = 1'b1;
                    restart_s = 1'b1;
                end else begin
                    drop_s = 1'b1;
                end
            end
            IN_FRAME: begin
                fwd_s = 1'b1;
                if (s_axis_disp.tuser && !(row_r == '0 && col_r == '0)) begin
                    restart_s   = 1'b1;
                    sof_early_s = 1'b1;
                end else begin
                    restart_s = 1'b0;
                end
            end
            default: begin
                drop_s = 1'b1;
            end
        endcase

        if (restart_s) begin
            eff_col_s = '0;
            eff_row_s = '0;
        end else begin
            eff_col_s = col_r;
            eff_row_s = row_r;
        end

        // Counters are authoritative: a line ends at the last column even
        // without tlast, and an early tlast ends it short.
        line_end_s  = fwd_s & ((eff_col_s == COL_LAST) | s_axis_disp.tlast);
        short_s     = fwd_s & s_axis_disp.tlast & (eff_col_s != COL_LAST);
        long_s      = fwd_s & ~s_axis_disp.tlast & (eff_col_s == COL_LAST);
        frame_end_s = line_end_s & (eff_row_s == ROW_LAST);
        out_tuser_s = fwd_s & (eff_row_s == '0) & (eff_col_s == '0);
        out_tlast_s = line_end_s;

        if (acc_s && fwd_s) begin
            if (frame_end_s) begin
                state_nxt_s = WAIT_SOF;
                col_nxt_s   = '0;
                row_nxt_s   = '0;
            end else if (line_end_s) begin
                state_nxt_s = IN_FRAME;
                col_nxt_s   = '0;
                row_nxt_s   = eff_row_s + ROW_W'(1);
            end else begin
                state_nxt_s = IN_FRAME;
                col_nxt_s   = eff_col_s + COL_W'(1);
                row_nxt_s   = eff_row_s;
            end
        end else begin
            state_nxt_s = state_r;
        end

        for (int i = 0; i < N; i++) begin
            pix_s = 32'(eff_col_s) * 32'(N) + 32'(i);
            if (pix_s < 32'(MAX_DISP)) begin
                out_data_s[DATA_WIDTH*i +: DATA_WIDTH] = '0;
            end else begin
                out_data_s[DATA_WIDTH*i +: DATA_WIDTH] =
                    sat_shift(s_axis_disp.tdata[DATA_WIDTH*i +: DATA_WIDTH]);
            end
        end
    end

    // FSM state and geometry counters.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= WAIT_SOF;
            col_r   <= '0;
            row_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            col_r   <= col_nxt_s;
            row_r   <= row_nxt_s;
        end
    end

    // Single output register stage; loads whenever the downstream slot is free.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= '0;
            m_tlast_r  <= 1'b0;
            m_tuser_r  <= 1'b0;
        end else if (s_ready_s) begin
            m_tvalid_r <= acc_s & fwd_s;
            if (acc_s && fwd_s) begin
                m_tdata_r <= out_data_s;
                m_tlast_r <= out_tlast_s;
                m_tuser_r <= out_tuser_s;
            end else begin
                m_tdata_r <= m_tdata_r;
                m_tlast_r <= m_tlast_r;
                m_tuser_r <= m_tuser_r;
            end
        end else begin
            m_tvalid_r <= m_tvalid_r;
        end
    end

    // Sticky geometry errors and the drop counter; err_clr wins over a set.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_short_line <= 1'b0;
            err_long_line  <= 1'b0;
            err_sof_early  <= 1'b0;
            drop_cnt       <= 16'd0;
        end else if (err_clr) begin
            err_short_line <= 1'b0;
            err_long_line  <= 1'b0;
            err_sof_early  <= 1'b0;
            drop_cnt       <= 16'd0;
        end else begin
            err_short_line <= err_short_line | (acc_s & short_s);
            err_long_line  <= err_long_line  | (acc_s & long_s);
            err_sof_early  <= err_sof_early  | (acc_s & sof_early_s);
            if (acc_s && drop_s && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end else begin
                drop_cnt <= drop_cnt;
            end
        end
    end

    // One-cycle pulse when the final beat of a frame is accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= acc_s & frame_end_s;
        end
    end
endmodule

// File: tb/tb_disp_mask_scale.sv
// Randomised self-checking bench for disp_mask_scale with a frame-level model.
module tb_disp_mask_scale;
    localparam int W = 16, H = 2, MD = 8, N = 4, SH = 2, DW = 8, TW = 32;
    localparam int C = W / N;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        err_clr = 1'b0;
    logic        err_short_line, err_long_line, err_sof_early, frame_done;
    logic [15:0] drop_cnt;

    disp_mask_scale_if #(.DATA_W(TW)) s_if ();
    disp_mask_scale_if #(.DATA_W(TW)) m_if ();

    disp_mask_scale #(
        .MAX_DISP(MD), .MAX_SAMPLES_PER_CLOCK(N), .AXIS_TDATA_WIDTH(TW),
        .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SCALE_SHIFT(SH)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_disp(s_if), .m_axis_disp(m_if),
        .err_clr(err_clr), .err_short_line(err_short_line),
        .err_long_line(err_long_line), .err_sof_early(err_sof_early),
        .frame_done(frame_done), .drop_cnt(drop_cnt)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
    } beat_t;

    beat_t q[$];
    bit    md_in_frame = 1'b0;
    int    md_col = 0, md_row = 0;
    bit    e_short = 1'b0, e_long = 1'b0, e_sof = 1'b0, e_fd = 1'b0;
    int    e_drop = 0;

    logic [31:0] log_data [256];
    bit          log_last [256];
    bit          log_user [256];
    int          out_n = 0;
    int          fd_count = 0;

    // Masked/scaled expectation for one beat at a given beat column.
    function automatic logic [31:0] expect_data(int col, logic [31:0] d);
        logic [31:0] r;
        int v;
        r = 32'd0;
        for (int i = 0; i < N; i++) begin
            v = int'(d[8*i +: 8]) * (1 << SH);
            if (col * N + i < MD) v = 0;
            if (v > 255) v = 255;
            r[8*i +: 8] = 8'(v);
        end
        return r;
    endfunction

    // Compare outputs reflecting previous edges, then fold in the beat that
    // the coming rising edge will accept.
    always @(negedge aclk) begin
        bit acc, u, l, lend, s_short, s_long, s_sof, s_drop;
        logic [31:0] d;
        if (!aresetn) begin
            q.delete();
            md_in_frame = 1'b0; md_col = 0; md_row = 0;
            e_short = 1'b0; e_long = 1'b0; e_sof = 1'b0; e_fd = 1'b0; e_drop = 0;
            check("rst_tvalid", m_if.tvalid, 1'b0);
            check("rst_tdata", m_if.tdata, 32'h0);
            check("rst_markers", {m_if.tlast, m_if.tuser, frame_done}, 3'b000);
            check("rst_errs", {err_short_line, err_long_line, err_sof_early}, 3'b000);
            check("rst_drop", drop_cnt, 16'h0);
        end else begin
            check("s_tready", s_if.tready, m_if.tready | !m_if.tvalid);
            check("m_tvalid", m_if.tvalid, q.size() != 0);
            if (m_if.tvalid && q.size() != 0) begin
                check("m_tdata", m_if.tdata, q[0].data);
                check("m_tlast", m_if.tlast, q[0].last);
                check("m_tuser", m_if.tuser, q[0].user);
                if (m_if.tready) begin
                    if (out_n < 256) begin
                        log_data[out_n] = m_if.tdata;
                        log_last[out_n] = m_if.tlast;
                        log_user[out_n] = m_if.tuser;
                    end
                    out_n++;
                    void'(q.pop_front());
                end
            end
            check("frame_done", frame_done, e_fd);
            if (frame_done) fd_count++;
            check("err_short_line", err_short_line, e_short);
            check("err_long_line", err_long_line, e_long);
            check("err_sof_early", err_sof_early, e_sof);
            check("drop_cnt", drop_cnt, 16'(e_drop));

            acc = s_if.tvalid && s_if.tready;
            e_fd = 1'b0;
            s_short = 1'b0; s_long = 1'b0; s_sof = 1'b0; s_drop = 1'b0;
            if (acc) begin
                d = s_if.tdata; u = s_if.tuser; l = s_if.tlast;
                if (!md_in_frame && !u) begin
                    s_drop = 1'b1;
                end else begin
                    if (u && (md_col != 0 || md_row != 0)) begin
                        s_sof = md_in_frame;
                        md_col = 0; md_row = 0;
                    end
                    lend = (md_col == C - 1) || l;
                    s_short = l && (md_col != C - 1);
                    s_long = !l && (md_col == C - 1);
                    q.push_back('{expect_data(md_col, d), lend, (md_col == 0 && md_row == 0)});
                    md_in_frame = 1'b1;
                    if (lend && md_row == H - 1) begin
                        e_fd = 1'b1; md_in_frame = 1'b0; md_col = 0; md_row = 0;
                    end else if (lend) begin
                        md_col = 0; md_row++;
                    end else begin
                        md_col++;
                    end
                end
            end
            if (err_clr) begin
                e_short = 1'b0; e_long = 1'b0; e_sof = 1'b0; e_drop = 0;
            end else begin
                e_short |= s_short; e_long |= s_long; e_sof |= s_sof;
                if (s_drop && e_drop < 65535) e_drop++;
            end
        end
    end

    // ---------------- m_tready driver ----------------
    int tr_mode = 0;
    int tr_cyc = 0;
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            tr_cyc++;
            case (tr_mode)
                1: m_if.tready = 1'($urandom_range(0, 1));
                2: m_if.tready = ((tr_cyc % 4) == 0) || ((tr_cyc % 4) == 3);
                default: m_if.tready = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(logic [31:0] d, bit u, bit l);
        bit got;
        got = 1'b0;
        s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tuser = u; s_if.tlast = l;
        for (int k = 0; k < 200; k++) begin
            @(negedge aclk);
            got = s_if.tready;
            @(posedge aclk);
            #1;
            if (got) break;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end
    endtask

    task automatic idle(int n);
        s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge aclk);
        #1;
        err_clr = 1'b0;
    endtask

    // One well-formed frame; beat sp_idx carries sp_val when sp_idx >= 0.
    task automatic send_frame(bit rnd, logic [31:0] fixed, int sp_idx, logic [31:0] sp_val);
        logic [31:0] d;
        for (int b = 0; b < C * H; b++) begin
            d = rnd ? $urandom : fixed;
            if (b == sp_idx) d = sp_val;
            send(d, b == 0, (b % C) == C - 1);
        end
    endtask

    initial begin
        int base, fd0;
        s_if.tvalid = 1'b0; s_if.tdata = 32'h0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        idle(2);

        // Nominal frame.
        base = out_n; fd0 = fd_count;
        send_frame(1'b0, 32'h05050505, -1, 32'h0);
        idle(3);
        check("nom_count", out_n - base, 8);
        check("nom_b0", log_data[base], 32'h00000000);
        check("nom_b1", log_data[base + 1], 32'h00000000);
        check("nom_b2", log_data[base + 2], 32'h14141414);
        check("nom_b3", log_data[base + 3], 32'h14141414);
        check("nom_b5", log_data[base + 5], 32'h00000000);
        check("nom_last", {log_last[base + 2], log_last[base + 3], log_last[base + 7]}, 3'b011);
        check("nom_user", {log_user[base], log_user[base + 4]}, 2'b10);
        check("nom_fd", fd_count - fd0, 1);

        // Saturation on col 3.
        base = out_n;
        send_frame(1'b1, 32'h0, 3, 32'h50505050);
        idle(3);
        check("sat_b3", log_data[base + 3], 32'hFFFFFFFF);

        // Backpressure 1-0-0-1, then random.
        tr_mode = 2;
        base = out_n;
        send_frame(1'b1, 32'h0, -1, 32'h0);
        idle(8);
        check("bp_count", out_n - base, 8);
        tr_mode = 1;
        for (int f = 0; f < 4; f++) send_frame(1'b1, 32'h0, -1, 32'h0);
        idle(10);
        tr_mode = 0;
        idle(2);

        // Leading garbage.
        pulse_clr();
        base = out_n;
        for (int k = 0; k < 3; k++) send($urandom, 1'b0, 1'b0);
        idle(3);
        check("garb_no_out", out_n - base, 0);
        send_frame(1'b1, 32'h0, -1, 32'h0);
        idle(3);
        check("garb_drop", drop_cnt, 16'd3);
        check("garb_count", out_n - base, 8);

        // Short line at col 2 of row 0.
        pulse_clr();
        base = out_n;
        send($urandom, 1'b1, 1'b0);
        send($urandom, 1'b0, 1'b0);
        send(32'h09090909, 1'b0, 1'b1);
        for (int c = 0; c < C; c++) send($urandom, 1'b0, c == C - 1);
        idle(3);
        check("short_flag", err_short_line, 1'b1);
        check("short_last", log_last[base + 2], 1'b1);
        check("short_b2", log_data[base + 2], 32'h24242424);
        check("short_row1", log_user[base + 3], 1'b0);
        pulse_clr();
        idle(1);
        check("short_clr", err_short_line, 1'b0);

        // Long line: missing tlast at col C-1.
        base = out_n;
        for (int b = 0; b < C * H; b++) send($urandom, b == 0, (b % C == C - 1) && b != C - 1);
        idle(3);
        check("long_flag", err_long_line, 1'b1);
        check("long_last", log_last[base + C - 1], 1'b1);
        pulse_clr();

        // Early SOF at row 1, col 1.
        base = out_n;
        for (int b = 0; b < C + 1; b++) send($urandom, b == 0, b == C - 1);
        send(32'h33333333, 1'b1, 1'b0);
        for (int b = 1; b < C * H; b++) send($urandom, 1'b0, (b % C) == C - 1);
        idle(3);
        check("sof_flag", err_sof_early, 1'b1);
        check("sof_user", log_user[base + C + 1], 1'b1);
        check("sof_data", log_data[base + C + 1], 32'h0);
        check("sof_count", out_n - base, C + 1 + C * H);

        // Reset mid-frame, then a clean frame.
        tr_mode = 1;
        for (int b = 0; b < 3; b++) send($urandom, b == 0, 1'b0);
        s_if.tvalid = 1'b0;
        aresetn = 1'b0;
        @(negedge aclk);
        check("mrst_tvalid", m_if.tvalid, 1'b0);
        check("mrst_sof", err_sof_early, 1'b0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        tr_mode = 0;
        idle(2);
        base = out_n;
        send_frame(1'b1, 32'h0, -1, 32'h0);
        idle(3);
        check("mrst_count", out_n - base, 8);
        check("mrst_user", log_user[base], 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
